// File: rtl/para.sv
// Shared flit format constants for the NoC datapath blocks.
package para;
  localparam int unsigned FLIT_SIZE  = 32;
  localparam int unsigned HEADER_LEN = 2;

  localparam logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'b00;
  localparam logic [HEADER_LEN-1:0] BODY_FLIT   = 2'b01;
  localparam logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'b10;
  localparam logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b11;
endpackage

// File: rtl/one_to_n_distributor.sv
// Wormhole 1-to-N demultiplexer: routes packets by head-flit destination
// into per-port 2-entry FIFOs, dropping malformed or misrouted flits.
module one_to_n_distributor
  import para::*;
#(
  parameter int unsigned N       = 6,
  parameter int unsigned DST_LEN = 3,
  parameter int unsigned DST_POS = FLIT_SIZE - HEADER_LEN - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FLIT_SIZE-1:0]   in,
  input  logic                   in_valid,
  output logic                   in_avail,
  output logic [FLIT_SIZE*N-1:0] out,
  output logic [N-1:0]           out_valid,
  input  logic [N-1:0]           out_avail,
  output logic                   err,
  output logic [15:0]            drop_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DST_LEN-1:0]    lock_q, lock_d;
  logic [FLIT_SIZE-1:0]  slot_q, slot_d;
  logic                  slot_valid_q, slot_valid_d;
  logic [FLIT_SIZE-1:0]  head_q [N];
  logic [FLIT_SIZE-1:0]  head_d [N];
  logic [FLIT_SIZE-1:0]  tail_q [N];
  logic [FLIT_SIZE-1:0]  tail_d [N];
  logic [N-1:0]          v0_q, v0_d, v1_q, v1_d;
  logic                  err_q, err_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  logic [HEADER_LEN-1:0] typ;
  logic [DST_LEN-1:0]    dst;
  logic                  dst_ok;
  logic                  push, drop, slot_leaves;
  logic [DST_LEN-1:0]    push_port;

  assign typ    = slot_q[FLIT_SIZE-1 -: HEADER_LEN];
  assign dst    = slot_q[DST_POS -: DST_LEN];
  assign dst_ok = 32'(dst) < N;

  // Routing FSM; "full" is judged on current occupancy only so in_avail never sees out_avail
  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    push      = 1'b0;
    drop      = 1'b0;
    err_d     = 1'b0;
    push_port = lock_q;
    if (slot_valid_q) begin
      case (state_q)
        ST_IDLE: begin
          if ((typ == HEAD_FLIT || typ == SINGLE_FLIT) && dst_ok) begin
            push_port = dst;
            if (!v1_q[dst]) begin
              push = 1'b1;
              if (typ == HEAD_FLIT) begin
                lock_d  = dst;
                state_d = ST_FWD;
              end
            end
          end else begin
            drop  = 1'b1;
            err_d = 1'b1;
            if (typ == HEAD_FLIT) state_d = ST_DROP;
          end
        end
        ST_FWD: begin
          if (typ == BODY_FLIT || typ == TAIL_FLIT) begin
            if (!v1_q[lock_q]) begin
              push = 1'b1;
              if (typ == TAIL_FLIT) state_d = ST_IDLE;
            end
          end else begin
            drop  = 1'b1;
            err_d = 1'b1;
          end
        end
        ST_DROP: begin
          drop = 1'b1;
          if (typ == HEAD_FLIT || typ == SINGLE_FLIT) err_d = 1'b1;
          if (typ == TAIL_FLIT) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign slot_leaves = push | drop;
  assign in_avail    = ~slot_valid_q | slot_leaves;

  always_comb begin
    slot_d       = slot_q;
    slot_valid_d = slot_valid_q & ~slot_leaves;
    if (in_valid && in_avail) begin
      slot_d       = in;
      slot_valid_d = 1'b1;
    end
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Per-port 2-entry FIFO: pop shifts tail into head, push fills the first free entry
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    v0_d   = v0_q;
    v1_d   = v1_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (v0_q[i] && out_avail[i]) begin
        head_d[i] = tail_q[i];
        v0_d[i]   = v1_q[i];
        v1_d[i]   = 1'b0;
      end
      if (push && push_port == DST_LEN'(i)) begin
        if (!v0_d[i]) begin
          head_d[i] = slot_q;
          v0_d[i]   = 1'b1;
        end else begin
          tail_d[i] = slot_q;
          v1_d[i]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lock_q       <= '0;
      slot_q       <= '0;
      slot_valid_q <= 1'b0;
      v0_q         <= '0;
      v1_q         <= '0;
      err_q        <= 1'b0;
      drop_cnt_q   <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      lock_q       <= lock_d;
      slot_q       <= slot_d;
      slot_valid_q <= slot_valid_d;
      v0_q         <= v0_d;
      v1_q         <= v1_d;
      err_q        <= err_d;
      drop_cnt_q   <= drop_cnt_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_out
    assign out[FLIT_SIZE*g +: FLIT_SIZE] = head_q[g];
  end

  assign out_valid = v0_q;
  assign err       = err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/one_to_n_distributor.md
# one_to_n_distributor

Wormhole demultiplexer that takes one flit stream and spreads it over N output streams. It is the egress-side counterpart of the N-to-1 merge stage. A head or single flit's destination field picks the output port. Body and tail flits follow the locked port until the tail. Each output has a 2-entry FIFO, so downstream backpressure on one port does not corrupt packet order.

## Interface
- N, 6, number of output ports
- DST_LEN, 3, width of the destination field; must satisfy 2^DST_LEN ≥ N
- DST_POS, FLIT_SIZE-HEADER_LEN-1, MSB index of the destination field, which sits directly below the flit-type header
- Flit constants FLIT_SIZE, HEADER_LEN, HEAD_FLIT, BODY_FLIT, TAIL_FLIT, SINGLE_FLIT come from para.sv.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in  in  FLIT_SIZE  input flit
- in_valid  in  1  input flit present
- in_avail  out  1  block accepts `in` this cycle
- out  out  FLIT_SIZE*N  port i occupies bits [FLIT_SIZE*i+FLIT_SIZE-1 : FLIT_SIZE*i]
- out_valid  out  N  port i flit present
- out_avail  in  N  downstream i consumes `out` slice i this cycle
- err  out  1  one-cycle pulse on a protocol or destination error
- drop_cnt  out  16  count of dropped flits, saturates at 16'hFFFF

## Operation
- Transfer rules:
  - An input transfer occurs when in_valid && in_avail; the flit is captured into the input slot.
  - An output transfer on port i occurs when out_valid[i] && out_avail[i].
- Flit decode: type = slot[FLIT_SIZE-1 -: HEADER_LEN]; dst = slot[DST_POS -: DST_LEN].
- The state machine has three states. IDLE is the reset state.
  - IDLE, SINGLE, dst<N: push to FIFO[dst]; stay in IDLE.
  - IDLE, HEAD, dst<N: push to FIFO[dst]; set lock_port = dst; go to FWD.
  - IDLE, HEAD, dst≥N: drop the flit; pulse err; go to DROP.
  - IDLE, SINGLE, dst≥N: drop the flit; pulse err; stay in IDLE.
  - IDLE, BODY or TAIL: drop the flit; pulse err; stay in IDLE.
  - FWD, BODY: push to FIFO[lock_port].
  - FWD, TAIL: push to FIFO[lock_port]; go to IDLE.
  - FWD, HEAD or SINGLE: drop the flit; pulse err; stay in FWD.
  - DROP, BODY: drop silently.
  - DROP, TAIL: drop silently; go to IDLE.
  - DROP, HEAD or SINGLE: drop; pulse err; stay in DROP.
- Forwarding requires FIFO[target].count < 2. If the target FIFO is full, the slot holds its flit and the state is unchanged.
- Dropping always completes in one cycle. Every dropped flit increments drop_cnt, saturating.
- in_avail = ~slot_valid | slot_leaves, where slot_leaves means the slot flit is pushed or dropped this cycle. in_avail has no combinational path from out_avail.
- Each FIFO is 2 entries and in-order:
  - out slice i is the head entry; out_valid[i] = (count_i != 0).
  - Push and pop in the same cycle at count 1 leaves count at 1.
  - A push at count 2 never occurs.
- Packets from a single input stream are never interleaved across ports. Blocking the locked port stalls the whole input (head-of-line blocking by design).

## Timing
- Reset values:
  - out_valid = 0, out = 0, err = 0, drop_cnt = 0.
  - Slot empty, so in_avail = 1.
  - FIFOs empty, state IDLE, lock_port = 0.
- Latency: a flit accepted at cycle t is in the slot at t+1, is pushed at the end of t+1, and shows out_valid at t+2 when the FIFO has space.
- Throughput: 1 flit/cycle sustained to any single port while its out_avail is held high.
- err is asserted during the cycle after the offending flit sits in the slot, for exactly one cycle per dropped offending flit.
- Reset mid-packet: slot, FIFOs and lock are all discarded in the same cycle; the next flit is decoded in IDLE.
- Storage limit: with the target blocked, at most 3 flits are accepted (2 in the FIFO, 1 in the slot). in_avail is then 0 until a pop frees FIFO space.

## Test plan
- SINGLE with dst=3 accepted at t → out_valid = 6'b001000 at t+2 with the flit on slice 3; no other port valid; err stays 0.
- HEAD(dst=1), BODY, BODY, TAIL on consecutive cycles, out_avail all 1 → four consecutive flits on port 1 from t+2; in_avail stays 1; state returns to IDLE.
- 5-flit packet to port 2 with out_avail[2]=0 → in_avail falls to 0 after 3 accepts. Raising out_avail[2] then delivers all 5 flits in order with no duplicates.
- HEAD(dst=6), BODY, TAIL with N=6 → no out_valid on any port; err pulses once; drop_cnt=3; a following SINGLE(dst=0) is delivered on port 0.
- BODY while IDLE, then HEAD(dst=4) with a SINGLE injected mid-packet, then TAIL → two err pulses; drop_cnt=2; the HEAD and TAIL alone appear on port 4.
- Assert rst while a packet to port 5 is locked with FIFO[5] holding 2 flits → next cycle out_valid = 0, in_avail = 1; a new HEAD(dst=0) routes to port 0.
